dcache_setassoc: RTL and testbench
==================================

DCACHE_SETASSOC -- requirements
Module: dcache_setassoc

Interface
REQ-001 Parameter: WAYS, 2, ways per set; legal values 2 or 4.
REQ-002 Parameter: SETS, 4, sets; power of two, at least 2.
REQ-003 Parameter: N_THREADS, 4, hardware threads; power of two.
REQ-004 Parameter: PADDR_W, 20, physical address width; line size is 16 bytes (4 x 32-bit words); offset = paddr[3:0], set = paddr[4 +: log2(SETS)], tag = the remaining upper bits.
REQ-005 Port: clk  in  1  clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  one clock; reset is synchronous and active-low.
REQ-007 Port: thread  in  log2(N_THREADS)  issuing thread id.
REQ-008 Port: paddr  in  PADDR_W  load/store lookup address; isvalid  in  1  lookup slot valid.
REQ-009 Port: flag_mem  in  1  memory op; dtlb_miss  in  1  translation failed.
REQ-010 Port: miss  out  1  lookup miss; data  out  32  addressed word of hit way.
REQ-011 Port: mem_req_ren  out  1; mem_req_raddr  out  PADDR_W; mem_req_wen  out  1; mem_req_waddr  out  PADDR_W; mem_req_wcacheline  out  128.
REQ-012 Port: mem_rec_en  in  1; mem_rec_addr  in  PADDR_W; mem_rec_cacheline  in  128.
REQ-013 Port: stalled  out  N_THREADS  per-thread stall bit.
REQ-014 Port: store_en  in  1; store_isbyte  in  1; store_addr  in  PADDR_W; store_data  in  32  committed store.

Function
REQ-015 Lookup is combinational: hit = any way in set with valid and tag equal; miss = !hit | dtlb_miss; data = word paddr[3:2] of hit way, don't-care on miss.
REQ-016 Each set holds one pending-miss record: pending bit, pending tag, victim way.
REQ-017 Miss issue: on flag_mem & isvalid & !dtlb_miss & miss with set not pending, the next cycle carries mem_req_ren=1 for exactly one cycle with mem_req_raddr = line-aligned paddr; the set becomes pending with the request tag; the victim is chosen now: the first invalid way, else the replacement choice (REQ-025).
REQ-018 On any qualifying miss, pending or not, listener[thread] = {valid, set} is recorded and stalled[thread]=1 the next cycle; a miss to an already-pending set issues no memory request.
REQ-019 Fill: mem_rec_en with set pending and mem_rec_addr tag equal to the pending tag writes mem_rec_cacheline into the victim way, marks it valid and clean, and clears pending; a non-matching fill is ignored.
REQ-020 Writeback: if the victim way was valid and dirty at fill time, the next cycle carries mem_req_wen=1 for one cycle, with mem_req_waddr = {old tag, set, 4'b0} and mem_req_wcacheline = old data.
REQ-021 Wake: a fill clears stalled[i] and listener[i].valid for every valid listener whose set matches; a new stall of the same thread in the same cycle takes priority.
REQ-022 Store: store_en writes a byte (store_isbyte; lane = store_addr[3:0]) or a word (lane = store_addr[3:2]) into the hitting way and sets dirty; a non-hitting store is dropped.
REQ-023 Store and fill in the same cycle on the victim way: the store lands first; the writeback carries the store-updated data.
REQ-024 Miss and fill to the same set in the same cycle: if the request tag equals the fill tag, no request is issued, no stall occurs, and the thread replays to a hit; otherwise a new request issues, because pending is released that cycle.
REQ-025 Replacement state updates on every lookup hit, store hit, and fill.

Reset
REQ-026 While rst=0 at a clock edge, clear all valid, dirty, and pending bits, all listeners, and stalled; set mem_req_ren=0 and mem_req_wen=0; set mem_req_raddr, mem_req_waddr, and mem_req_wcacheline to 0; set replacement state to 0.
REQ-027 Reset mid-miss discards the outstanding request; a later mem_rec_en for it is ignored, because no set is pending.

Configuration
REQ-028 With DCACHE_LRU_EN defined, each set keeps true LRU order: for WAYS=2 one bit, for WAYS=4 six pairwise bits; the victim is the least recently used way.
REQ-029 Without DCACHE_LRU_EN, each set keeps a log2(WAYS)-bit round-robin pointer, advanced only on fill; REQ-025 reduces to fill-only updates.

Verification
REQ-030 Cold load, thread 1, paddr 0x00040: miss=1; next cycle mem_req_ren=1, raddr=0x00040, stalled=4'b0010; fill of 0x00040 -> stalled=0; replayed load hits with the correct word.
REQ-031 Threads 0 and 2 miss on the same line on consecutive cycles -> exactly one mem_req_ren pulse; one fill clears both stall bits.
REQ-032 WAYS=2, SETS=4: fill tags A and B into set 0, store a word to A, then miss on tag C -> victim per LRU or round-robin; on fill of C, mem_req_wen=1 with waddr equal to A's line and the stored word present.
REQ-033 Store byte 0x5A to hit line offset 0x7 in the same cycle as the fill evicting that line -> writeback cacheline byte 7 = 0x5A.
REQ-034 Drop rst to 0 while a miss is pending, release it, then deliver the matching fill -> no array change; stalled=0; mem_req_wen stays 0.

Source files
------------

// File: rtl/dcache_setassoc_if.sv
// Memory-side bus of dcache_setassoc: line read/writeback requests go out, line fills come back.
// The cache drives the master modport; the memory model drives the slave modport.
interface dcache_setassoc_if #(
   parameter int PADDR_W = 20
);
   logic               mem_req_ren;
   logic [PADDR_W-1:0] mem_req_raddr;
   logic               mem_req_wen;
   logic [PADDR_W-1:0] mem_req_waddr;
   logic [127:0]       mem_req_wcacheline;
   logic               mem_rec_en;
   logic [PADDR_W-1:0] mem_rec_addr;
   logic [127:0]       mem_rec_cacheline;

   modport master (
      output mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
      input  mem_rec_en, mem_rec_addr, mem_rec_cacheline
   );

   modport slave (
      input  mem_req_ren, mem_req_raddr, mem_req_wen, mem_req_waddr, mem_req_wcacheline,
      output mem_rec_en, mem_rec_addr, mem_rec_cacheline
   );
endinterface

// File: rtl/dcache_setassoc.sv
// Set-associative, non-blocking data cache with one outstanding miss per set and per-thread stalls.
// Define DCACHE_LRU_EN for true-LRU replacement; the default build uses a per-set round-robin pointer.
module dcache_setassoc #(
   parameter int WAYS      = 2,
   parameter int SETS      = 4,
   parameter int N_THREADS = 4,
   parameter int PADDR_W   = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(N_THREADS)-1:0] thread,
   input  logic [PADDR_W-1:0]           paddr,
   input  logic                         isvalid,
   input  logic                         flag_mem,
   input  logic                         dtlb_miss,
   output logic                         miss,
   output logic [31:0]                  data,
   output logic [N_THREADS-1:0]         stalled,
   input  logic                         store_en,
   input  logic                         store_isbyte,
   input  logic [PADDR_W-1:0]           store_addr,
   input  logic [31:0]                  store_data,
   dcache_setassoc_if.master            mem
);

   localparam int WAY_W = $clog2(WAYS);
   localparam int SET_W = $clog2(SETS);
   localparam int TAG_W = PADDR_W - 4 - SET_W;
`ifdef DCACHE_LRU_EN
   localparam int REPL_W = WAYS * (WAYS - 1) / 2;
`else
   localparam int REPL_W = WAY_W;
`endif

   logic [WAYS-1:0]   valid_q    [SETS];
   logic [WAYS-1:0]   dirty_q    [SETS];
   logic [TAG_W-1:0]  tag_q      [SETS][WAYS];
   logic [127:0]      line_q     [SETS][WAYS];
   logic [REPL_W-1:0] repl_q     [SETS];
   logic [REPL_W-1:0] repl_n     [SETS];
   logic [SETS-1:0]   pend_q;
   logic [TAG_W-1:0]  pend_tag_q [SETS];
   logic [WAY_W-1:0]  pend_way_q [SETS];
   logic [N_THREADS-1:0] lis_valid_q;
   logic [SET_W-1:0]  lis_set_q  [N_THREADS];

   logic [SET_W-1:0] lk_set, st_set, fl_set;
   logic [TAG_W-1:0] lk_tag, st_tag, fl_tag;
   logic             lk_hit, st_hit;
   logic [WAY_W-1:0] lk_way, st_way, fl_way, victim;
   logic [127:0]     st_line, wb_line;
   logic [WAYS-1:0]  vld_after;
   logic             st_do, fl_do, st_on_victim, wb_dirty;
   logic             qual_miss, fill_same, replay, do_stall, do_issue;
   logic             unused_bits;

   assign lk_set = paddr[4 +: SET_W];
   assign lk_tag = paddr[PADDR_W-1 -: TAG_W];
   assign st_set = store_addr[4 +: SET_W];
   assign st_tag = store_addr[PADDR_W-1 -: TAG_W];
   assign fl_set = mem.mem_rec_addr[4 +: SET_W];
   assign fl_tag = mem.mem_rec_addr[PADDR_W-1 -: TAG_W];
   assign unused_bits = ^{paddr[1:0], mem.mem_rec_addr[3:0]};

`ifdef DCACHE_LRU_EN
   // Pair bit (i,j), i<j, is 1 when way i was used more recently than way j.
   function automatic int pair_idx(input int i, input int j);
      return i * WAYS - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   function automatic logic [REPL_W-1:0] lru_touch(input logic [REPL_W-1:0] st,
                                                   input logic [WAY_W-1:0]  w);
      logic [REPL_W-1:0] r;
      r = st;
      for (int i = 0; i < WAYS; i++) begin
         for (int j = i + 1; j < WAYS; j++) begin
            if (int'(w) == i) r[pair_idx(i, j)] = 1'b1;
            else if (int'(w) == j) r[pair_idx(i, j)] = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic logic [WAY_W-1:0] lru_pick(input logic [REPL_W-1:0] st);
      logic [WAY_W-1:0] r;
      logic             oldest;
      r = '0;
      for (int k = WAYS - 1; k >= 0; k--) begin
         oldest = 1'b1;
         for (int m = 0; m < WAYS; m++) begin
            if (m < k && !st[pair_idx(m, k)]) oldest = 1'b0;
            if (m > k && st[pair_idx(k, m)]) oldest = 1'b0;
         end
         if (oldest) r = WAY_W'(k);
      end
      return r;
   endfunction

   logic lk_use;
   assign lk_use = flag_mem & isvalid & ~dtlb_miss & lk_hit;
`endif

   always_comb begin
      lk_hit = 1'b0;
      lk_way = '0;
      st_hit = 1'b0;
      st_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
         end
         if (valid_q[st_set][w] && tag_q[st_set][w] == st_tag) begin
            st_hit = 1'b1;
            st_way = WAY_W'(w);
         end
      end
   end

   assign miss = ~lk_hit | dtlb_miss;
   assign data = line_q[lk_set][lk_way][{paddr[3:2], 5'b00000} +: 32];

   always_comb begin
      st_line = line_q[st_set][st_way];
      if (store_isbyte) st_line[{store_addr[3:0], 3'b000} +: 8] = store_data[7:0];
      else              st_line[{store_addr[3:2], 5'b00000} +: 32] = store_data;
   end

   assign st_do        = store_en & st_hit;
   assign fl_do        = mem.mem_rec_en & pend_q[fl_set] & (pend_tag_q[fl_set] == fl_tag);
   assign fl_way       = pend_way_q[fl_set];
   // A store landing on the line being evicted must reach memory in the writeback.
   assign st_on_victim = st_do && (st_set == fl_set) && (st_way == fl_way);
   assign wb_dirty     = valid_q[fl_set][fl_way] && (dirty_q[fl_set][fl_way] || st_on_victim);
   assign wb_line      = st_on_victim ? st_line : line_q[fl_set][fl_way];

   // A fill to the same set releases pending this cycle; a matching tag simply replays as a hit.
   assign qual_miss = flag_mem & isvalid & ~dtlb_miss & ~lk_hit;
   assign fill_same = fl_do && (fl_set == lk_set);
   assign replay    = qual_miss && fill_same && (fl_tag == lk_tag);
   assign do_stall  = qual_miss && !replay;
   assign do_issue  = do_stall && (!pend_q[lk_set] || fill_same);

   always_comb begin
      repl_n = repl_q;
`ifdef DCACHE_LRU_EN
      if (lk_use) repl_n[lk_set] = lru_touch(repl_n[lk_set], lk_way);
      if (st_do)  repl_n[st_set] = lru_touch(repl_n[st_set], st_way);
      if (fl_do)  repl_n[fl_set] = lru_touch(repl_n[fl_set], fl_way);
`else
      if (fl_do)  repl_n[fl_set] = repl_q[fl_set] + 1'b1;
`endif
   end

   // Victim sees this cycle's fill as already valid so it never picks the way just filled while empty ones remain.
   always_comb begin
      vld_after = valid_q[lk_set];
      if (fill_same) vld_after[fl_way] = 1'b1;
`ifdef DCACHE_LRU_EN
      victim = lru_pick(repl_n[lk_set]);
`else
      victim = repl_n[lk_set];
`endif
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!vld_after[w]) victim = WAY_W'(w);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s]    <= '0;
            dirty_q[s]    <= '0;
            repl_q[s]     <= '0;
            pend_tag_q[s] <= '0;
            pend_way_q[s] <= '0;
         end
         for (int t = 0; t < N_THREADS; t++) lis_set_q[t] <= '0;
         pend_q                 <= '0;
         lis_valid_q            <= '0;
         stalled                <= '0;
         mem.mem_req_ren        <= 1'b0;
         mem.mem_req_raddr      <= '0;
         mem.mem_req_wen        <= 1'b0;
         mem.mem_req_waddr      <= '0;
         mem.mem_req_wcacheline <= '0;
      end else begin
         repl_q          <= repl_n;
         mem.mem_req_ren <= do_issue;
         mem.mem_req_wen <= fl_do && wb_dirty;
         if (do_issue) mem.mem_req_raddr <= {paddr[PADDR_W-1:4], 4'b0000};
         if (fl_do && wb_dirty) begin
            mem.mem_req_waddr      <= {tag_q[fl_set][fl_way], fl_set, 4'b0000};
            mem.mem_req_wcacheline <= wb_line;
         end
         if (st_do) dirty_q[st_set][st_way] <= 1'b1;
         if (fl_do) begin
            valid_q[fl_set][fl_way] <= 1'b1;
            dirty_q[fl_set][fl_way] <= 1'b0;
            pend_q[fl_set]          <= 1'b0;
            for (int t = 0; t < N_THREADS; t++) begin
               if (lis_valid_q[t] && lis_set_q[t] == fl_set) begin
                  lis_valid_q[t] <= 1'b0;
                  stalled[t]     <= 1'b0;
               end
            end
         end
         if (do_issue) begin
            pend_q[lk_set]     <= 1'b1;
            pend_tag_q[lk_set] <= lk_tag;
            pend_way_q[lk_set] <= victim;
         end
         if (do_stall) begin
            lis_valid_q[thread] <= 1'b1;
            lis_set_q[thread]   <= lk_set;
            stalled[thread]     <= 1'b1;
         end
      end
   end

   // Line data and tags carry no reset; valid bits alone decide what is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (st_do) line_q[st_set][st_way] <= st_line;
         if (fl_do) begin
            line_q[fl_set][fl_way] <= mem.mem_rec_cacheline;
            tag_q[fl_set][fl_way]  <= fl_tag;
         end
      end
   end

endmodule

// File: tb/tb_dcache_setassoc.sv
// Directed self-checking bench for dcache_setassoc (WAYS=2, SETS=4, default round-robin build).
// Set = paddr[5:4], tag = paddr[19:6]; every step drives inputs 1ns after a rising edge.
module tb_dcache_setassoc;
   localparam int PW = 20;

   typedef struct {
      logic          rst_n;
      logic [1:0]    thread;
      logic [PW-1:0] paddr;
      logic          isvalid;
      logic          flag_mem;
      logic          dtlb_miss;
      logic          rec_en;
      logic [PW-1:0] rec_addr;
      logic [127:0]  rec_line;
      logic          st_en;
      logic          st_byte;
      logic [PW-1:0] st_addr;
      logic [31:0]   st_data;
   } stim_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    thread;
   logic [PW-1:0] paddr;
   logic          isvalid, flag_mem, dtlb_miss;
   logic          miss;
   logic [31:0]   data;
   logic [3:0]    stalled;
   logic          store_en, store_isbyte;
   logic [PW-1:0] store_addr;
   logic [31:0]   store_data;

   int vectors     = 0;
   int miscompares = 0;

   dcache_setassoc_if #(.PADDR_W(PW)) mem_bus ();

   dcache_setassoc #(.WAYS(2), .SETS(4), .N_THREADS(4), .PADDR_W(PW)) dut (
      .clk          (clk),
      .rst          (rst),
      .thread       (thread),
      .paddr        (paddr),
      .isvalid      (isvalid),
      .flag_mem     (flag_mem),
      .dtlb_miss    (dtlb_miss),
      .miss         (miss),
      .data         (data),
      .stalled      (stalled),
      .store_en     (store_en),
      .store_isbyte (store_isbyte),
      .store_addr   (store_addr),
      .store_data   (store_data),
      .mem          (mem_bus)
   );

   always #5 clk = ~clk;

   function automatic stim_t nop();
      stim_t s;
      s.rst_n = 1'b1;   s.thread = '0;   s.paddr = '0;
      s.isvalid = 1'b0; s.flag_mem = 1'b0; s.dtlb_miss = 1'b0;
      s.rec_en = 1'b0;  s.rec_addr = '0; s.rec_line = '0;
      s.st_en = 1'b0;   s.st_byte = 1'b0; s.st_addr = '0; s.st_data = '0;
      return s;
   endfunction

   function automatic stim_t ld(input logic [1:0] t, input logic [PW-1:0] a);
      stim_t s;
      s = nop();
      s.thread = t; s.paddr = a; s.isvalid = 1'b1; s.flag_mem = 1'b1;
      return s;
   endfunction

   function automatic stim_t peek(input logic [PW-1:0] a);
      stim_t s;
      s = nop();
      s.paddr = a;
      return s;
   endfunction

   function automatic stim_t with_fill(input stim_t s0, input logic [PW-1:0] a, input logic [127:0] l);
      stim_t s;
      s = s0;
      s.rec_en = 1'b1; s.rec_addr = a; s.rec_line = l;
      return s;
   endfunction

   function automatic stim_t with_store(input stim_t s0, input logic b, input logic [PW-1:0] a,
                                        input logic [31:0] d);
      stim_t s;
      s = s0;
      s.st_en = 1'b1; s.st_byte = b; s.st_addr = a; s.st_data = d;
      return s;
   endfunction

   function automatic logic [127:0] mkline(input logic [31:0] base);
      return {base + 32'd3, base + 32'd2, base + 32'd1, base};
   endfunction

   task automatic applyStimulus(input stim_t s);
      @(posedge clk);
      #1;
      rst          = s.rst_n;
      thread       = s.thread;
      paddr        = s.paddr;
      isvalid      = s.isvalid;
      flag_mem     = s.flag_mem;
      dtlb_miss    = s.dtlb_miss;
      store_en     = s.st_en;
      store_isbyte = s.st_byte;
      store_addr   = s.st_addr;
      store_data   = s.st_data;
      mem_bus.mem_rec_en        = s.rec_en;
      mem_bus.mem_rec_addr      = s.rec_addr;
      mem_bus.mem_rec_cacheline = s.rec_line;
      #3;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      stim_t s;
      logic [127:0] l1, l2, l3, l4, l5, l6, exp_line;
      l1 = mkline(32'hA000_0000);
      l2 = mkline(32'hB000_0000);
      l3 = mkline(32'hC000_0000);
      l4 = mkline(32'hD000_0000);
      l5 = mkline(32'h1111_0000);
      l6 = mkline(32'hE000_0000);

      // Reset state
      s = nop(); s.rst_n = 1'b0;
      applyStimulus(s);
      applyStimulus(s);
      checkOutput("rst_stalled", stalled, 0);
      checkOutput("rst_ren", mem_bus.mem_req_ren, 0);
      checkOutput("rst_wen", mem_bus.mem_req_wen, 0);
      checkOutput("rst_raddr", mem_bus.mem_req_raddr, 0);
      checkOutput("rst_waddr", mem_bus.mem_req_waddr, 0);
      checkOutput("rst_wline", mem_bus.mem_req_wcacheline, 0);

      // Cold load by thread 1, fill, replay
      applyStimulus(ld(2'd1, 20'h00048));
      checkOutput("cold_miss", miss, 1);
      applyStimulus(nop());
      checkOutput("cold_ren", mem_bus.mem_req_ren, 1);
      checkOutput("cold_raddr", mem_bus.mem_req_raddr, 20'h00040);
      checkOutput("cold_stalled", stalled, 4'b0010);
      applyStimulus(nop());
      checkOutput("cold_ren_pulse", mem_bus.mem_req_ren, 0);
      checkOutput("cold_still_stalled", stalled, 4'b0010);
      applyStimulus(with_fill(nop(), 20'h00040, l1));
      applyStimulus(nop());
      checkOutput("cold_wake", stalled, 0);
      checkOutput("cold_no_wb", mem_bus.mem_req_wen, 0);
      applyStimulus(ld(2'd1, 20'h00048));
      checkOutput("cold_replay_hit", miss, 0);
      checkOutput("cold_replay_data", data, 32'hA000_0002);

      // Two threads miss on one line: a single request, one fill wakes both
      applyStimulus(ld(2'd0, 20'h00080));
      checkOutput("shared_miss0", miss, 1);
      applyStimulus(ld(2'd2, 20'h00084));
      checkOutput("shared_ren", mem_bus.mem_req_ren, 1);
      checkOutput("shared_raddr", mem_bus.mem_req_raddr, 20'h00080);
      checkOutput("shared_stall0", stalled, 4'b0001);
      checkOutput("shared_miss2", miss, 1);
      applyStimulus(nop());
      checkOutput("shared_no_second_req", mem_bus.mem_req_ren, 0);
      checkOutput("shared_stall02", stalled, 4'b0101);
      applyStimulus(with_fill(nop(), 20'h00080, l2));
      checkOutput("shared_ren_idle", mem_bus.mem_req_ren, 0);
      applyStimulus(nop());
      checkOutput("shared_wake", stalled, 0);
      checkOutput("shared_no_wb", mem_bus.mem_req_wen, 0);

      // Dirty eviction: store into line A, miss on C, A is written back
      applyStimulus(with_store(nop(), 1'b0, 20'h00044, 32'hDEAD_BEEF));
      applyStimulus(ld(2'd3, 20'h00044));
      checkOutput("store_word_hit", miss, 0);
      checkOutput("store_word_data", data, 32'hDEAD_BEEF);
      applyStimulus(ld(2'd3, 20'h000C0));
      checkOutput("evict_miss", miss, 1);
      applyStimulus(nop());
      checkOutput("evict_ren", mem_bus.mem_req_ren, 1);
      checkOutput("evict_raddr", mem_bus.mem_req_raddr, 20'h000C0);
      checkOutput("evict_stalled", stalled, 4'b1000);
      applyStimulus(with_fill(nop(), 20'h000C0, l3));
      applyStimulus(peek(20'h00040));
      exp_line = l1;
      exp_line[63:32] = 32'hDEAD_BEEF;
      checkOutput("wb_wen", mem_bus.mem_req_wen, 1);
      checkOutput("wb_waddr", mem_bus.mem_req_waddr, 20'h00040);
      checkOutput("wb_line", mem_bus.mem_req_wcacheline, exp_line);
      checkOutput("wb_wake", stalled, 0);
      checkOutput("wb_a_evicted", miss, 1);
      applyStimulus(peek(20'h000C8));
      checkOutput("wb_wen_pulse", mem_bus.mem_req_wen, 0);
      checkOutput("wb_c_hit", miss, 0);
      checkOutput("wb_c_data", data, 32'hC000_0002);

      // Byte store to the victim in the same cycle as its eviction
      applyStimulus(ld(2'd0, 20'h00100));
      checkOutput("byte_miss", miss, 1);
      applyStimulus(nop());
      checkOutput("byte_ren", mem_bus.mem_req_ren, 1);
      checkOutput("byte_raddr", mem_bus.mem_req_raddr, 20'h00100);
      applyStimulus(with_store(with_fill(nop(), 20'h00100, l4), 1'b1, 20'h00087, 32'h0000_005A));
      applyStimulus(peek(20'h00108));
      exp_line = l2;
      exp_line[63:56] = 8'h5A;
      checkOutput("byte_wen", mem_bus.mem_req_wen, 1);
      checkOutput("byte_waddr", mem_bus.mem_req_waddr, 20'h00080);
      checkOutput("byte_wline", mem_bus.mem_req_wcacheline, exp_line);
      checkOutput("byte_new_hit", miss, 0);
      checkOutput("byte_new_data", data, 32'hD000_0002);
      checkOutput("byte_wake", stalled, 0);

      // Reset while a miss is outstanding; the late fill must be ignored
      applyStimulus(ld(2'd2, 20'h00140));
      applyStimulus(nop());
      checkOutput("rmid_ren", mem_bus.mem_req_ren, 1);
      checkOutput("rmid_stalled", stalled, 4'b0100);
      s = nop(); s.rst_n = 1'b0;
      applyStimulus(s);
      applyStimulus(nop());
      checkOutput("rmid_stalled_clr", stalled, 0);
      checkOutput("rmid_ren_clr", mem_bus.mem_req_ren, 0);
      checkOutput("rmid_raddr_clr", mem_bus.mem_req_raddr, 0);
      applyStimulus(with_fill(nop(), 20'h00140, l5));
      applyStimulus(peek(20'h00140));
      checkOutput("rmid_no_wb", mem_bus.mem_req_wen, 0);
      checkOutput("rmid_stalled_after", stalled, 0);
      checkOutput("rmid_fill_ignored", miss, 1);

      // Miss coinciding with the fill of the same line: replay, no request, no stall
      applyStimulus(ld(2'd1, 20'h00200));
      applyStimulus(nop());
      checkOutput("race_ren", mem_bus.mem_req_ren, 1);
      checkOutput("race_raddr", mem_bus.mem_req_raddr, 20'h00200);
      checkOutput("race_stalled", stalled, 4'b0010);
      applyStimulus(with_fill(ld(2'd3, 20'h00204), 20'h00200, l6));
      checkOutput("race_miss_now", miss, 1);
      applyStimulus(ld(2'd3, 20'h00204));
      checkOutput("race_no_req", mem_bus.mem_req_ren, 0);
      checkOutput("race_no_stall", stalled, 0);
      checkOutput("race_replay_hit", miss, 0);
      checkOutput("race_replay_data", data, 32'hE000_0001);

      // Translation failure forces a miss but never requests memory
      s = ld(2'd3, 20'h00204); s.dtlb_miss = 1'b1;
      applyStimulus(s);
      checkOutput("tlb_miss", miss, 1);
      applyStimulus(nop());
      checkOutput("tlb_no_req", mem_bus.mem_req_ren, 0);
      checkOutput("tlb_no_stall", stalled, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
